// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
// Kept separate so the FSM encoding and iteration limits are defined once.
package div_pkg;

  localparam int                   DIV_WIDTH     = 32;
  localparam logic [4:0]           DIV_ITER_LAST = 5'd31;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/neg_32_bits.sv
// Combinational two's-complement negation (invert and add one).
// Used for operand magnitudes at capture and for result sign correction.
module neg_32_bits
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] i_val,
  output logic [DIV_WIDTH-1:0] o_neg
);

  assign o_neg = ~i_val + DIV_WIDTH'(1);

endmodule

// File: rtl/div_32_bits.sv
// Signed/unsigned 32-bit restoring divider, one quotient bit per clock.
// Fixed 33-edge latency from start to done; results held until the next FIX.
module div_32_bits
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_t           r_state;
  logic [4:0]           r_cnt;
  logic [DIV_WIDTH:0]   r_rem;
  logic [DIV_WIDTH-1:0] r_dvd;
  logic [DIV_WIDTH-1:0] r_dsr;
  logic [DIV_WIDTH-1:0] r_a_raw;
  logic                 r_sa;
  logic                 r_sb;
  logic                 r_zero;
  logic [DIV_WIDTH-1:0] r_q;
  logic [DIV_WIDTH-1:0] r_r;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;

  logic                 w_sa;
  logic                 w_sb;
  logic [DIV_WIDTH-1:0] w_neg0_in;
  logic [DIV_WIDTH-1:0] w_neg1_in;
  logic [DIV_WIDTH-1:0] w_neg0;
  logic [DIV_WIDTH-1:0] w_neg1;
  logic [DIV_WIDTH+1:0] w_shift;
  logic [DIV_WIDTH+1:0] w_trial;

  assign w_sa = A[WIDTH-1] & signed_op;
  assign w_sb = B[WIDTH-1] & signed_op;

  // Negators are shared: operands while idle, quotient/remainder in FIX.
  assign w_neg0_in = (r_state == FIX) ? r_dvd            : A;
  assign w_neg1_in = (r_state == FIX) ? r_rem[DIV_WIDTH-1:0] : B;

  neg_32_bits u_neg0 (
    .i_val (w_neg0_in),
    .o_neg (w_neg0)
  );

  neg_32_bits u_neg1 (
    .i_val (w_neg1_in),
    .o_neg (w_neg1)
  );

  // Extra top bit of the trial acts as the borrow: set means rem < divisor.
  assign w_shift = {r_rem, r_dvd[DIV_WIDTH-1]};
  assign w_trial = w_shift - {2'b00, r_dsr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_a_raw <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_zero  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_dvd   <= w_sa ? w_neg0 : A;
            r_dsr   <= w_sb ? w_neg1 : B;
            r_a_raw <= A;
            r_zero  <= (B == '0);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_trial[DIV_WIDTH+1] ? w_shift[DIV_WIDTH:0] : w_trial[DIV_WIDTH:0];
          r_dvd <= {r_dvd[DIV_WIDTH-2:0], ~w_trial[DIV_WIDTH+1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == DIV_ITER_LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_zero) begin
            r_q   <= DIV_ZERO_Q;
            r_r   <= r_a_raw;
            r_dbz <= 1'b1;
          end else begin
            r_q   <= (r_sa ^ r_sb) ? w_neg0 : r_dvd;
            r_r   <= r_sa ? w_neg1 : r_rem[DIV_WIDTH-1:0];
            r_dbz <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Q           = r_q;
  assign R           = r_r;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_32_bits.sv
// Self-checking bench for div_32_bits: directed vector table, multi-cycle
// corner sequences, and random operations against an arithmetic model.
module tb_div_32_bits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Q;
  logic [31:0] R;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int op_num = 0;

  always #5 clk = ~clk;

  div_32_bits #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; signed uses 64-bit arithmetic so the
  // INT_MIN / -1 case wraps naturally when truncated back to 32 bits.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dbz);
    longint la;
    longint lb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dbz = 1'b1;
    end else if (!s) begin
      q   = a / b;
      r   = a % b;
      dbz = 1'b0;
    end else begin
      la  = $signed(a);
      lb  = $signed(b);
      lq  = la / lb;
      lr  = la % lb;
      q   = lq[31:0];
      r   = lr[31:0];
      dbz = 1'b0;
    end
  endfunction

  // Called at #1 after an edge; start is sampled at the next edge.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_op = s;
    A         = a;
    B         = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    bit seen;
    seen     = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    check("done_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int lat;
    int bcnt;
    launch(s, a, b);
    wait_done(lat, bcnt);
    op_num++;
    $display("op %0d %s: s=%0b A=%h B=%h -> Q=%h R=%h dbz=%0b lat=%0d",
             op_num, tag, s, a, b, Q, R, div_by_zero, lat);
    check({tag, "_Q"},   Q, eq);
    check({tag, "_R"},   R, er);
    check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
    check({tag, "_lat"}, lat, 32'd33);
  endtask

  initial begin
    int          lat;
    int          bcnt;
    int          done_cnt;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mq;
    logic [31:0] mr;
    logic        mdbz;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
    tbl[3]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    tbl[4]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    tbl[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    tbl[9]  = '{1'b1, 32'hF000_0000,  32'd0,          32'hFFFF_FFFF,  32'hF000_0000,  1'b1};
    tbl[10] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_Q",    Q, 32'd0);
    check("rst_R",    R, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dbz",  {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Timing of the first op: busy for exactly 33 cycles, done one cycle.
    launch(1'b0, 32'd100, 32'd7);
    check("t_busy_after_start", {31'b0, busy}, 32'd1);
    wait_done(lat, bcnt);
    check("t_lat",          lat,  32'd33);
    check("t_busy_run",     bcnt, 32'd32);
    check("t_busy_at_done", {31'b0, busy}, 32'd0);
    check("t_Q",            Q, 32'd14);
    check("t_R",            R, 32'd2);
    @(posedge clk);
    #1;
    check("t_done_pulse",   {31'b0, done}, 32'd0);
    check("t_Q_held",       Q, 32'd14);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz);
    end

    // start during RUN is ignored; results from the previous op stay put.
    launch(1'b0, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    check("ign_R_held", R, 32'd5);
    signed_op = 1'b0;
    A         = 32'd9;
    B         = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    $display("op ignore: 50/5 with late start -> Q=%h R=%h lat=%0d", Q, R, lat);
    check("ign_Q",   Q, 32'd10);
    check("ign_R",   R, 32'd0);
    check("ign_lat", lat, 32'd27);

    // New start in the done cycle is accepted.
    run_op("b2b", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Reset at iteration 10 aborts the operation.
    launch(1'b1, 32'd1000, 32'hFFFF_FFFD);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_Q",    Q, 32'd0);
    check("mrst_R",    R, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_dbz",  {31'b0, div_by_zero}, 32'd0);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_cnt++;
    end
    $display("op abort: reset mid-run, done/busy samples after reset=%0d", done_cnt);
    check("mrst_no_done", done_cnt, 32'd0);
    run_op("post_rst", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);

    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      model(rs, ra, rb, mq, mr, mdbz);
      run_op($sformatf("rnd%0d", i), rs, ra, rb, mq, mr, mdbz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
